// File: rtl/seq_lock_ctrl.sv
// rtl/seq_lock_ctrl.sv - keypad sequence lock with tick-enabled FSM and timed lockout
// All state advances only on divider ticks; reset clears everything regardless of tick.
module seq_lock_ctrl #(
   parameter int unsigned CLK_HZ        = 2,
   parameter int unsigned TICK_HZ       = 1,
   parameter int unsigned N_KEYS        = 4,
   parameter int unsigned CODE_LEN      = 5,
   parameter logic [63:0] CODE          = 64'h104,
   parameter int unsigned MAX_FAILS     = 3,
   parameter int unsigned LOCKOUT_TICKS = 8
) (
   input  logic                                iCLK,
   input  logic                                inRESET,
   input  logic [N_KEYS-1:0]                   iKEY,
   input  logic                                iLOCK,
   output logic                                oTICK,
   output logic                                oUNLOCK,
   output logic                                oGREEN,
   output logic                                oRED,
   output logic [1:0]                          oSTATE,
   output logic [$clog2(CODE_LEN+1)-1:0]       oPOS,
   output logic [$clog2(MAX_FAILS+1)-1:0]      oFAILS
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned KW  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
   localparam int unsigned PW  = $clog2(CODE_LEN + 1);
   localparam int unsigned FW  = $clog2(MAX_FAILS + 1);
   localparam int unsigned CW  = $clog2(LOCKOUT_TICKS + 1);
   localparam logic [CODE_LEN*KW-1:0] CODE_P = CODE[CODE_LEN*KW-1:0];

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'b00,
      ST_OPEN    = 2'b01,
      ST_LOCKOUT = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       div_q, div_d;
   logic                tick_q, tick_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic [FW-1:0]       fails_q, fails_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_KEYS-1:0]   prev_q, prev_d;
   logic                green_q, green_d;

   logic                tick;
   logic                press;
   logic                multi;
   logic [KW-1:0]       sym;
   logic [FW-1:0]       fails_inc;

   function automatic logic [KW-1:0] code_at(input logic [PW-1:0] p);
      return CODE_P[p*KW +: KW];
   endfunction

   always_ff @(posedge iCLK) begin
      if (!inRESET) begin
         state_q <= ST_ENTRY;
         div_q   <= '0;
         tick_q  <= 1'b0;
         pos_q   <= '0;
         fails_q <= '0;
         cnt_q   <= '0;
         prev_q  <= '0;
         green_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         pos_q   <= pos_d;
         fails_q <= fails_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         green_q <= green_d;
      end
   end

   always_comb begin
      tick   = (div_q == DW'(DIV - 1));
      div_d  = tick ? '0 : div_q + DW'(1);
      tick_d = tick;
   end

   // Multi-key presses never match; sym is only meaningful when exactly one key is down.
   always_comb begin
      sym = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (iKEY[i]) sym = KW'(i);
      end
      multi     = (iKEY & (iKEY - N_KEYS'(1))) != '0;
      press     = (iKEY != '0) && (prev_q == '0);
      fails_inc = (fails_q == FW'(MAX_FAILS)) ? fails_q : fails_q + FW'(1);
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      fails_d = fails_q;
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      green_d = green_q;
      if (tick) begin
         prev_d  = iKEY;
         green_d = 1'b0;
         unique case (state_q)
            ST_ENTRY: begin
               if (iLOCK) begin
                  pos_d = '0;
               end else if (press) begin
                  if (!multi && sym == code_at(pos_q)) begin
                     green_d = 1'b1;
                     if (pos_q == PW'(CODE_LEN - 1)) begin
                        state_d = ST_OPEN;
                        pos_d   = '0;
                        fails_d = '0;
                     end else begin
                        pos_d = pos_q + PW'(1);
                     end
                  end else begin
                     fails_d = fails_inc;
                     pos_d   = (!multi && sym == code_at(PW'(0))) ? PW'(1) : '0;
                     if (fails_inc == FW'(MAX_FAILS)) begin
                        state_d = ST_LOCKOUT;
                        cnt_d   = CW'(LOCKOUT_TICKS);
                        pos_d   = '0;
                     end
                  end
               end
            end
            ST_OPEN: begin
               if (iLOCK) state_d = ST_ENTRY;
            end
            ST_LOCKOUT: begin
               if (cnt_q <= CW'(1)) begin
                  state_d = ST_ENTRY;
                  fails_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: state_d = ST_ENTRY;
         endcase
      end
   end

   always_comb begin
      oTICK   = tick_q;
      oSTATE  = state_q;
      oUNLOCK = (state_q == ST_OPEN);
      oRED    = (state_q == ST_LOCKOUT);
      oGREEN  = green_q;
      oPOS    = pos_q;
      oFAILS  = fails_q;
   end

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// tb/tb_seq_lock_ctrl.sv - table-driven scoreboard bench for seq_lock_ctrl
// Each row is one tick of stimulus plus the outputs expected right after that tick.
module tb_seq_lock_ctrl;

   localparam logic [1:0] E = 2'b00;
   localparam logic [1:0] O = 2'b01;
   localparam logic [1:0] L = 2'b10;

   typedef struct packed {
      logic [1:0] st;
      logic [2:0] pos;
      logic [1:0] fails;
      logic       green;
   } exp_t;

   typedef struct {
      logic [3:0] key;
      logic       lock;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] key;
   logic       lock;
   logic       o_tick, o_unlock, o_green, o_red;
   logic [1:0] o_state;
   logic [2:0] o_pos;
   logic [1:0] o_fails;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_lock_ctrl #(
      .CLK_HZ(2), .TICK_HZ(1), .N_KEYS(4), .CODE_LEN(5),
      .CODE(64'h104), .MAX_FAILS(3), .LOCKOUT_TICKS(8)
   ) dut (
      .iCLK(clk), .inRESET(rstn), .iKEY(key), .iLOCK(lock),
      .oTICK(o_tick), .oUNLOCK(o_unlock), .oGREEN(o_green), .oRED(o_red),
      .oSTATE(o_state), .oPOS(o_pos), .oFAILS(o_fails)
   );

   function automatic exp_t mk(input logic [1:0] st, input int pos, input int f, input logic g);
      exp_t x;
      x.st    = st;
      x.pos   = 3'(pos);
      x.fails = 2'(f);
      x.green = g;
      return x;
   endfunction

   task automatic add(input logic [3:0] k, input logic l, input logic [1:0] st,
                      input int pos, input int f, input logic g);
      vec_t v;
      v.key  = k;
      v.lock = l;
      v.e    = mk(st, pos, f, g);
      tbl.push_back(v);
   endtask

   task automatic step(input logic [3:0] k, input logic l, input exp_t e, input string name);
      exp_t x;
      key  = k;
      lock = l;
      sb.push_back(e);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (o_tick) break;
      end
      x = sb.pop_front();
      checks++;
      if (!o_tick) begin
         errors++;
         $display("FAIL %s: no tick within bound, got oTICK=%b want 1", name, o_tick);
      end else if ({o_state, o_pos, o_fails, o_green} !== x ||
                   o_unlock !== (x.st == O) || o_red !== (x.st == L)) begin
         errors++;
         $display("FAIL %s: got st=%b pos=%0d fails=%0d green=%b unlock=%b red=%b, want st=%b pos=%0d fails=%0d green=%b unlock=%b red=%b",
                  name, o_state, o_pos, o_fails, o_green, o_unlock, o_red,
                  x.st, x.pos, x.fails, x.green, x.st == O, x.st == L);
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({o_tick, o_unlock, o_green, o_red, o_state, o_pos, o_fails} !== 11'b0) begin
         errors++;
         $display("FAIL %s: got tick=%b unlock=%b green=%b red=%b st=%b pos=%0d fails=%0d, want all 0",
                  name, o_tick, o_unlock, o_green, o_red, o_state, o_pos, o_fails);
      end
   endtask

   task automatic do_reset(input int n_samples);
      rstn = 1'b0;
      key  = '0;
      lock = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_zero($sformatf("reset_hold%0d", i));
      end
      rstn = 1'b1;
      for (int j = 1; j <= n_samples; j++) begin
         @(negedge clk);
         checks++;
         if (o_tick !== (j % 2 == 0)) begin
            errors++;
            $display("FAIL tick_phase%0d: got oTICK=%b want %b", j, o_tick, j % 2 == 0);
         end
      end
   endtask

   initial begin
      rstn = 1'b0;
      key  = '0;
      lock = 1'b0;

      // correct code with idle ticks, then OPEN ignores presses, iLOCK relocks
      add(1,0,E,1,0,1); add(0,0,E,1,0,0); add(2,0,E,2,0,1); add(0,0,E,2,0,0);
      add(1,0,E,3,0,1); add(0,0,E,3,0,0); add(1,0,E,4,0,1); add(0,0,E,4,0,0);
      add(2,0,O,0,0,1); add(0,0,O,0,0,0); add(1,0,O,0,0,0); add(0,0,O,0,0,0);
      add(0,1,E,0,0,0); add(0,0,E,0,0,0);
      // key0 held for five ticks counts once
      add(1,0,E,1,0,1); add(1,0,E,1,0,0); add(1,0,E,1,0,0); add(1,0,E,1,0,0);
      add(1,0,E,1,0,0); add(0,0,E,1,0,0); add(0,1,E,0,0,0);
      // 0,1,1 then the full code clears the fail count
      add(1,0,E,1,0,1); add(0,0,E,1,0,0); add(2,0,E,2,0,1); add(0,0,E,2,0,0);
      add(2,0,E,0,1,0); add(0,0,E,0,1,0);
      add(1,0,E,1,1,1); add(0,0,E,1,1,0); add(2,0,E,2,1,1); add(0,0,E,2,1,0);
      add(1,0,E,3,1,1); add(0,0,E,3,1,0); add(1,0,E,4,1,1); add(0,0,E,4,1,0);
      add(2,0,O,0,0,1); add(0,0,O,0,0,0); add(0,1,E,0,0,0);
      // 0,0 restarts at position 1; two keys at once is a mismatch
      add(1,0,E,1,0,1); add(0,0,E,1,0,0); add(1,0,E,1,1,0); add(0,0,E,1,1,0);
      add(3,0,E,0,2,0); add(0,0,E,0,2,0);

      do_reset(6);
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].key, tbl[i].lock, tbl[i].e, $sformatf("vec%0d", i));

      // lockout: code and iLOCK ignored, exactly 8 ticks
      do_reset(2);
      step(8, 0, mk(E,0,1,0), "lo_p1");
      step(0, 0, mk(E,0,1,0), "lo_i1");
      step(8, 0, mk(E,0,2,0), "lo_p2");
      step(0, 0, mk(E,0,2,0), "lo_i2");
      step(8, 0, mk(L,0,3,0), "lo_enter");
      step(1, 0, mk(L,0,3,0), "lo_t1");
      step(0, 0, mk(L,0,3,0), "lo_t2");
      step(2, 0, mk(L,0,3,0), "lo_t3");
      step(0, 1, mk(L,0,3,0), "lo_t4");
      step(1, 0, mk(L,0,3,0), "lo_t5");
      step(0, 0, mk(L,0,3,0), "lo_t6");
      step(0, 0, mk(L,0,3,0), "lo_t7");
      step(0, 0, mk(E,0,0,0), "lo_exit");
      step(1, 0, mk(E,1,0,1), "lo_after");

      // reset in the middle of a lockout
      do_reset(2);
      step(8, 0, mk(E,0,1,0), "lr_p1");
      step(0, 0, mk(E,0,1,0), "lr_i1");
      step(8, 0, mk(E,0,2,0), "lr_p2");
      step(0, 0, mk(E,0,2,0), "lr_i2");
      step(8, 0, mk(L,0,3,0), "lr_enter");
      step(0, 0, mk(L,0,3,0), "lr_t1");
      step(0, 0, mk(L,0,3,0), "lr_t2");
      do_reset(2);
      step(1, 0, mk(E,1,0,1), "lr_after");

      // iLOCK wins over a correct press on the same tick
      do_reset(2);
      step(8, 0, mk(E,0,1,0), "sim_f");
      step(0, 0, mk(E,0,1,0), "sim_i0");
      step(1, 0, mk(E,1,1,1), "sim_p1");
      step(0, 0, mk(E,1,1,0), "sim_i1");
      step(2, 0, mk(E,2,1,1), "sim_p2");
      step(0, 0, mk(E,2,1,0), "sim_i2");
      step(1, 1, mk(E,0,1,0), "sim_lock");
      step(0, 0, mk(E,0,1,0), "sim_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
